// File: rtl/rsnn_readback_pkg.sv
// rsnn_readback_pkg: shared state encoding and vector layout for the parameter readback path
// Weights occupy bits WEIGHT_MSB:WEIGHT_LSB of the snapshot, neuron params PARAM_MSB:0.
package rsnn_readback_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    DONE   = 3'd3,
    PARITY = 3'd4
  } state_t;
  localparam int DEFAULT_WIDTH = 312;
  localparam int WEIGHT_MSB    = 311;
  localparam int WEIGHT_LSB    = 96;
  localparam int PARAM_MSB     = 95;
endpackage

// File: rtl/param_readback_serializer.sv
// param_readback_serializer: snapshots the parameter vector and streams it out MSB first over valid/ready
// Ports: clk, rst_n (async active-low), enable (freezes all state when low), start (level, IDLE only),
//   parallel_in[WIDTH], ready -> serial_out, bit_valid, busy, end_reading (one-cycle pulse in DONE).
// Option: READBACK_PARITY_EN appends one even-parity bit (XOR of the snapshot) after the data bits.
module param_readback_serializer
  import rsnn_readback_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             end_reading
);
  state_t             r_state;
  logic [WIDTH-1:0]   r_shadow;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_last;
`ifdef READBACK_PARITY_EN
  logic               r_par;
  assign serial_out = (r_state == PARITY) ? r_par : r_shadow[WIDTH-1];
  assign bit_valid  = enable && (r_state == SHIFT || r_state == PARITY);
`else
  assign serial_out = r_shadow[WIDTH-1];
  assign bit_valid  = enable && (r_state == SHIFT);
`endif
  assign busy        = (r_state != IDLE);
  assign end_reading = (r_state == DONE);
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_cnt    <= '0;
`ifdef READBACK_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else if (enable) begin
      case (r_state)
        IDLE:  if (start) r_state <= LOAD;
        LOAD: begin
          r_shadow <= parallel_in;
          r_cnt    <= '0;
          r_state  <= SHIFT;
`ifdef READBACK_PARITY_EN
          r_par    <= ^parallel_in;
`endif
        end
        SHIFT: if (ready) begin
          r_shadow <= {r_shadow[WIDTH-2:0], 1'b0};
          r_cnt    <= r_cnt + 1'b1;
`ifdef READBACK_PARITY_EN
          if (w_last) r_state <= PARITY;
`else
          if (w_last) r_state <= DONE;
`endif
        end
`ifdef READBACK_PARITY_EN
        PARITY: if (ready) r_state <= DONE;
`endif
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_param_readback_serializer.sv
// tb_param_readback_serializer: randomized self-checking bench comparing the serial stream to the snapshot
module tb_param_readback_serializer;
  localparam int W = 312;
`ifdef READBACK_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  logic         clk = 0;
  logic         rst_n = 0;
  logic         enable = 1;
  logic         start = 0;
  logic [W-1:0] parallel_in = '0;
  logic         ready = 1;
  logic         serial_out, bit_valid, busy, end_reading;
  int checks = 0;
  int errors = 0;
  logic [NB-1:0] got;
  int n, cycles, ends, end_cyc, last_cyc, first_cyc, hold_bad, en_bad, timed_out;

  param_readback_serializer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .parallel_in(parallel_in),
    .ready(ready), .serial_out(serial_out), .bit_valid(bit_valid), .busy(busy), .end_reading(end_reading)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [NB-1:0] exp_of(input logic [W-1:0] v);
`ifdef READBACK_PARITY_EN
    return {v, 1'($countones(v) % 2)};
`else
    return v;
`endif
  endfunction

  task automatic collect(input int stall_idx, input int stall_len, input int en_idx, input int en_len,
                         input int abort_at, input bit poke, input bit keep_start);
    int sc, ec;
    bit poked, fin;
    got = '0; n = 0; cycles = 0; ends = 0; end_cyc = -1; last_cyc = -1; first_cyc = -1;
    hold_bad = 0; en_bad = 0; timed_out = 0; sc = 0; ec = 0; poked = 0; fin = 0;
    @(negedge clk);
    start = 1; ready = 1; enable = 1;
    @(posedge clk);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      cycles++;
      start = keep_start; enable = 1; ready = 1;
      if (n == en_idx && ec < en_len) begin enable = 0; ec++; end
      if (n == stall_idx && sc < stall_len) begin ready = 0; sc++; end
      if (poke && !poked && n == 50) begin parallel_in = ~parallel_in; start = 1; poked = 1; end
      #1;
      if (end_reading) begin ends++; end_cyc = cycles; end
      if (!enable && bit_valid) en_bad++;
      if (!ready && !bit_valid) hold_bad++;
      if (bit_valid && first_cyc < 0) first_cyc = cycles;
      if (bit_valid && ready) begin got = {got[NB-2:0], serial_out}; n++; last_cyc = cycles; end
      if (!busy || n == abort_at) begin fin = 1; break; end
    end
    if (!fin) timed_out = 1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    #2;
    checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL reset_serial_out: got %b exp 0", serial_out); end
    checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid: got %b exp 0", bit_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (end_reading !== 1'b0) begin errors++; $display("FAIL reset_end_reading: got %b exp 0", end_reading); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_basic;
    logic [W-1:0] v;
    v = '0; v[W-1 -: 8] = 8'hA5;
    parallel_in = v;
    collect(-1, 0, -1, 0, -1, 0, 0);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout: got %0d exp 0", timed_out); end
    checks++; if (got !== exp_of(v)) begin errors++; $display("FAIL basic_stream: got %h exp %h", got, exp_of(v)); end
    checks++; if (got[NB-1 -: 8] !== 8'hA5) begin errors++; $display("FAIL basic_first8: got %h exp a5", got[NB-1 -: 8]); end
    checks++; if (ends != 1) begin errors++; $display("FAIL basic_end_count: got %0d exp 1", ends); end
    checks++; if (end_cyc != last_cyc + 1) begin errors++; $display("FAIL basic_end_timing: got %0d exp %0d", end_cyc, last_cyc + 1); end
    checks++; if (first_cyc != 2) begin errors++; $display("FAIL basic_first_valid: got %0d exp 2", first_cyc); end
    checks++; if (cycles != NB + 3) begin errors++; $display("FAIL basic_cycles: got %0d exp %0d", cycles, NB + 3); end
  endtask

  task automatic test_reset_mid_shift;
    logic [W-1:0] v;
    v = rnd_vec(); v[W-1] = 1'b1;
    parallel_in = v;
    collect(-1, 0, -1, 0, 5, 0, 0);
    checks++; if (n != 5) begin errors++; $display("FAIL midrst_transfers: got %0d exp 5", n); end
    #1 rst_n = 0;
    #1;
    checks++; if ({serial_out, bit_valid, busy, end_reading} !== 4'b0) begin errors++;
      $display("FAIL midrst_outputs: got %b exp 0000", {serial_out, bit_valid, busy, end_reading}); end
    @(negedge clk); rst_n = 1;
    v = rnd_vec();
    parallel_in = v;
    collect(-1, 0, -1, 0, -1, 0, 0);
    checks++; if (got !== exp_of(v)) begin errors++; $display("FAIL midrst_stream: got %h exp %h", got, exp_of(v)); end
    checks++; if (timed_out != 0 || ends != 1) begin errors++; $display("FAIL midrst_end: got to=%0d ends=%0d exp 0/1", timed_out, ends); end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] v;
    v = rnd_vec();
    parallel_in = v;
    collect(100, 3, -1, 0, -1, 0, 0);
    checks++; if (got !== exp_of(v)) begin errors++; $display("FAIL bp_stream: got %h exp %h", got, exp_of(v)); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_valid_drop: got %0d exp 0", hold_bad); end
    checks++; if (cycles != NB + 6) begin errors++; $display("FAIL bp_cycles: got %0d exp %0d", cycles, NB + 6); end
  endtask

  task automatic test_enable;
    logic [W-1:0] v;
    v = rnd_vec();
    parallel_in = v;
    collect(-1, 0, 150, 4, -1, 0, 0);
    checks++; if (got !== exp_of(v)) begin errors++; $display("FAIL en_stream: got %h exp %h", got, exp_of(v)); end
    checks++; if (en_bad != 0) begin errors++; $display("FAIL en_valid_high: got %0d exp 0", en_bad); end
    checks++; if (cycles != NB + 7) begin errors++; $display("FAIL en_cycles: got %0d exp %0d", cycles, NB + 7); end
  endtask

  task automatic test_snapshot;
    logic [W-1:0] v;
    int extra;
    v = rnd_vec();
    parallel_in = v;
    collect(-1, 0, -1, 0, -1, 1, 0);
    checks++; if (got !== exp_of(v)) begin errors++; $display("FAIL snap_stream: got %h exp %h", got, exp_of(v)); end
    extra = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); #1; if (busy) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL snap_second_pass: got %0d busy cycles exp 0", extra); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] v;
    v = rnd_vec();
    parallel_in = v;
    collect(-1, 0, -1, 0, -1, 0, 1);
    checks++; if (got !== exp_of(v)) begin errors++; $display("FAIL b2b_stream: got %h exp %h", got, exp_of(v)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy %b exp 0", busy); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy %b exp 1", busy); end
    start = 0;
    rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

`ifdef READBACK_PARITY_EN
  task automatic test_parity;
    logic [W-1:0] v;
    for (int ones = 7; ones <= 8; ones++) begin
      v = '0;
      while ($countones(v) < ones) v[$urandom_range(0, W - 1)] = 1'b1;
      parallel_in = v;
      collect(-1, 0, -1, 0, -1, 0, 0);
      checks++; if (got[0] !== 1'(ones % 2)) begin errors++; $display("FAIL parity_bit_%0d: got %b exp %b", ones, got[0], 1'(ones % 2)); end
      checks++; if (got[NB-1:1] !== v) begin errors++; $display("FAIL parity_data_%0d: got %h exp %h", ones, got[NB-1:1], v); end
      checks++; if (end_cyc != last_cyc + 1) begin errors++; $display("FAIL parity_end_%0d: got %0d exp %0d", ones, end_cyc, last_cyc + 1); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_shift();
    test_backpressure();
    test_enable();
    test_snapshot();
    test_back_to_back();
`ifdef READBACK_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_readback_serializer.md
Name: param_readback_serializer

Overview:
- Parallel-in, serial-out readback engine for the RSNN parameter store.
- It is the reader side of the serial parameter-load path. It snapshots the 312-bit weight/parameter vector and shifts it out one bit at a time, using a valid/ready handshake.
- Sits beside the parameter memory in the RSNN top level. Its output drives a debug/readback pin so loaded weights (311:96) and neuron params (95:0) can be verified off-chip.

Parameters:
- WIDTH, 312, bits in the snapshot vector.
- CNT_W, 9, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  already-synchronized global enable; low freezes all state.
- start  input  1  request a readback; level-sampled in IDLE.
- parallel_in  input  WIDTH  parameter vector to snapshot.
- ready  input  1  consumer accepts the current bit this cycle.
- serial_out  output  1  current bit, MSB first.
- bit_valid  output  1  serial_out holds a valid bit.
- busy  output  1  readback in progress (LOAD, SHIFT or DONE).
- end_reading  output  1  one-cycle pulse after the last bit transfers.

Behaviour:
- Reset (rst_n low, any time, including mid-transfer):
  - state=IDLE, shadow register=0, counter=0.
  - serial_out=0, bit_valid=0, busy=0, end_reading=0.
- States: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
- Every transition and register update requires enable=1. With enable=0, state, counter and shadow hold, and bit_valid is forced 0.
- IDLE:
  - start=1 and enable=1 -> LOAD next cycle.
  - start is ignored in every other state; no queueing.
- LOAD (exactly one cycle):
  - shadow <= parallel_in, counter <= 0, -> SHIFT.
  - parallel_in is sampled only here; later changes do not affect the transfer.
- SHIFT:
  - serial_out = shadow[WIDTH-1] (registered).
  - bit_valid = (state==SHIFT) && enable (combinational).
  - Transfer occurs on any edge with bit_valid && ready: shadow shifts left by 1 with 0 fill, and counter increments.
  - ready=0 holds the current bit indefinitely.
  - On the transfer with counter==WIDTH-1 -> DONE.
- DONE (one cycle):
  - end_reading=1 and busy=1, then -> IDLE.
  - end_reading is high only in DONE.
- Latency: first bit_valid two cycles after start is sampled. With ready held high, there are WIDTH+3 cycles from the start sample to the return to IDLE.
- busy=1 in LOAD, SHIFT and DONE.
- Counter never wraps: saturates conceptually at WIDTH-1 because SHIFT exits there.
- start held high continuously: a new readback begins in the IDLE cycle after DONE. This is a back-to-back pass, one idle cycle between passes.
- Bit order: parallel_in[311] first, parallel_in[0] last.

Optional Feature:
- Macro: READBACK_PARITY_EN.
- Defined:
  - A PARITY state follows the final data transfer.
  - serial_out = XOR of the snapshot (even parity over all WIDTH bits), bit_valid=1, same ready handshake.
  - DONE follows the parity transfer; the pass takes one extra bit.
  - Parity is accumulated during LOAD from parallel_in and held in a register.
- Not defined: no PARITY state, no parity register; SHIFT goes directly to DONE.

Decomposition:
- Shared package rsnn_readback_pkg:
  - state encoding constants: IDLE=0, LOAD=1, SHIFT=2, DONE=3, PARITY=4 (3-bit state).
  - default WIDTH=312.
  - weight/param split constants: WEIGHT_MSB=311, WEIGHT_LSB=96, PARAM_MSB=95.
- No sub-module required. Shift register, counter and FSM live in one module; the existing synchronizer is used upstream for start/ready where they come off-chip.

Test Plan:
- Reset mid-SHIFT: pull rst_n low after 5 transfers -> all outputs 0 asynchronously, state IDLE. A new start then reads the full vector from bit 311.
- Basic pass with ready=1: parallel_in={312'h…A5 in bits 311:304, rest 0} -> serial_out 1,0,1,0,0,1,0,1 then 304 zeros. end_reading pulses exactly once, in the cycle after the 312th transfer; total 315 cycles from the start sample.
- Backpressure: drop ready for 3 cycles at bit index 100 -> serial_out and the counter hold, bit_valid stays 1, no bit lost or duplicated.
- enable low: deassert enable for 4 cycles mid-SHIFT -> bit_valid=0 and all state frozen. On resume the stream continues from the held bit.
- Snapshot isolation and ignored start: change parallel_in and pulse start during SHIFT -> output stream matches the original snapshot, and no second pass is launched.
- READBACK_PARITY_EN defined: parallel_in with 7 ones -> 313th bit is 1 and end_reading follows it. With 8 ones the 313th bit is 0.
